// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types, constants and GF(2^8) helper
//
// Contents:
//   AES_NB, AES_NK         : column height in bytes and key length in columns
//   RCON_INIT, XTIME_POLY  : first round constant and GF(2^8) reduction byte
//   state_t                : key_expand_writer FSM states
//   byte_t, col_t, window_t: a byte, a 4-byte column (index = row), a 4x4 window (index = column)
//   xtime()                : multiply by x in GF(2^8) with a caller-supplied reduction byte
package aes_pkg;
    localparam int AES_NB = 4;
    localparam int AES_NK = 4;
    localparam logic [7:0] RCON_INIT  = 8'h01;
    localparam logic [7:0] XTIME_POLY = 8'h1B;

    typedef enum logic [2:0] {IDLE, LOAD, SUB, WR, DONE} state_t;

    typedef logic [7:0] byte_t;
    typedef byte_t [AES_NB-1:0] col_t;
    typedef col_t  [AES_NK-1:0] window_t;

    function automatic byte_t xtime(input byte_t b, input byte_t poly);
        return b[7] ? ({b[6:0], 1'b0} ^ poly) : {b[6:0], 1'b0};
    endfunction
endpackage

// File: rtl/key_expand_writer_if.sv
// rtl/key_expand_writer_if.sv - word-RAM write ports and S-box ROM port of the key expander
//
// Signals:
//   word_address0/1, word_ce0/1, word_we0/1, word_d0/1 : two word-RAM write ports
//   sbox_address0, sbox_ce0                             : S-box ROM read request
//   sbox_q0                                             : S-box data, one cycle after sbox_ce0
// Modports: master (key expander side), slave (memory / ROM side).
interface key_expand_writer_if #(
    parameter int ADDR_W = 9
);
    logic [ADDR_W-1:0] word_address0;
    logic              word_ce0;
    logic              word_we0;
    logic [31:0]       word_d0;
    logic [ADDR_W-1:0] word_address1;
    logic              word_ce1;
    logic              word_we1;
    logic [31:0]       word_d1;
    logic [7:0]        sbox_address0;
    logic              sbox_ce0;
    logic [7:0]        sbox_q0;

    modport master (
        output word_address0, word_ce0, word_we0, word_d0,
        output word_address1, word_ce1, word_we1, word_d1,
        output sbox_address0, sbox_ce0,
        input  sbox_q0
    );

    modport slave (
        input  word_address0, word_ce0, word_we0, word_d0,
        input  word_address1, word_ce1, word_we1, word_d1,
        input  sbox_address0, sbox_ce0,
        output sbox_q0
    );
endinterface

// File: rtl/key_window_regs.sv
// rtl/key_window_regs.sv - 4x4 byte sliding window holding the last four key columns
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears the window)
//   load       : replace the whole window with key_in
//   key_in     : initial four key columns
//   shift      : drop column 0, shift left, append new_col as column 3
//   new_col    : freshly generated column
//   window     : current window contents
module key_window_regs
    import aes_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    load,
    input  window_t key_in,
    input  logic    shift,
    input  col_t    new_col,
    output window_t window
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window <= '0;
        end else if (load) begin
            window <= key_in;
        end else if (shift) begin
            window <= {new_col, window[AES_NK-1:1]};
        end
    end
endmodule

// File: rtl/key_expand_writer.sv
// rtl/key_expand_writer.sv - AES-128 key schedule writing round-key bytes into the shared word RAM
//
// Optional feature macro: KEY_EXPAND_LOCK_EN (adds working_key input and LOCK_VALUE parameter).
// Ports:
//   ap_clk, ap_rst_n            : clock, asynchronous active-low reset
//   ap_start                    : start request, sampled in IDLE
//   ap_done, ap_ready           : one-cycle completion pulse (identical)
//   ap_idle                     : high in IDLE while ap_start is low
//   cipher_key[127:0]           : key, byte k at [127-8k -: 8]
//   working_key[27:0]           : (KEY_EXPAND_LOCK_EN only) unlock word
//   mem                         : key_expand_writer_if master (word RAM writes, S-box reads)
// Byte (row r, column c) of the schedule goes to word address r*ROW_STRIDE + c as {24'd0, byte}.
module key_expand_writer
    import aes_pkg::*;
#(
    parameter int NROUND     = 10,
    parameter int ROW_STRIDE = 120,
    parameter int ADDR_W     = 9
`ifdef KEY_EXPAND_LOCK_EN
    ,
    parameter logic [27:0] LOCK_VALUE = 28'h5A3C3A5
`endif
)(
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                ap_start,
    output logic                ap_done,
    output logic                ap_idle,
    output logic                ap_ready,
    input  logic [127:0]        cipher_key,
`ifdef KEY_EXPAND_LOCK_EN
    input  logic [27:0]         working_key,
`endif
    key_expand_writer_if.master mem
);
    localparam int NCOL = AES_NB * (NROUND + 1);
    localparam int CW   = $clog2(NCOL + 1);

    state_t        state;
    logic [CW-1:0] col;
    logic          half;      // 0: rows 0/1 this cycle, 1: rows 2/3
    logic [2:0]    sub_cnt;
    byte_t         rcon;
    col_t          s;         // SubWord(RotWord(temp)) ^ rcon once SUB completes

    window_t       window;
    window_t       key_cols;
    col_t          t_col;
    col_t          new_col;
    col_t          src;
    logic [1:0]    row0;
    logic [1:0]    row1;
    logic          wr_en;
    byte_t         wr_mask;
    byte_t         xt_poly;

`ifdef KEY_EXPAND_LOCK_EN
    logic [27:0] mask;
    logic        mask_unused;
    assign mask        = working_key ^ LOCK_VALUE;
    assign mask_unused = ^mask[27:16];
    assign wr_mask     = mask[7:0];
    assign xt_poly     = XTIME_POLY ^ mask[15:8];
`else
    assign wr_mask = '0;
    assign xt_poly = XTIME_POLY;
`endif

    // Key byte k belongs to column k/4, row k%4: a byte reversal of cipher_key.
    assign key_cols = {<<8{cipher_key}};

    // Column index multiple of 4 means SUB has just produced s.
    assign t_col   = (col[1:0] == 2'b00) ? s : window[AES_NK-1];
    assign new_col = window[0] ^ t_col;

    key_window_regs u_window (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .load    (state == IDLE && ap_start),
        .key_in  (key_cols),
        .shift   (state == WR && half),
        .new_col (new_col),
        .window  (window)
    );

    function automatic logic [ADDR_W-1:0] waddr(input logic [1:0] row, input logic [CW-1:0] c);
        return ADDR_W'(32'(row) * ROW_STRIDE + 32'(c));
    endfunction

    assign wr_en = (state == LOAD) || (state == WR);
    assign src   = (state == LOAD) ? window[col[1:0]] : new_col;
    assign row0  = {half, 1'b0};
    assign row1  = {half, 1'b1};

    assign mem.word_ce0      = wr_en;
    assign mem.word_we0      = wr_en;
    assign mem.word_address0 = waddr(row0, col);
    assign mem.word_d0       = {24'd0, src[row0] ^ wr_mask};
    assign mem.word_ce1      = wr_en;
    assign mem.word_we1      = wr_en;
    assign mem.word_address1 = waddr(row1, col);
    assign mem.word_d1       = {24'd0, src[row1] ^ wr_mask};

    // RotWord order: temp[1], temp[2], temp[3], temp[0] for sub_cnt 0..3.
    assign mem.sbox_address0 = window[AES_NK-1][sub_cnt[1:0] + 2'd1];
    assign mem.sbox_ce0      = (state == SUB) && !sub_cnt[2];

    assign ap_done  = (state == DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (state == IDLE) && !ap_start;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state   <= IDLE;
            col     <= '0;
            half    <= 1'b0;
            sub_cnt <= '0;
            rcon    <= RCON_INIT;
            s       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ap_start) begin
                        state <= LOAD;
                        col   <= '0;
                        half  <= 1'b0;
                        rcon  <= RCON_INIT;
                    end
                end
                LOAD: begin
                    half <= ~half;
                    if (half) begin
                        col <= col + 1'b1;
                        if (col == CW'(AES_NK - 1)) begin
                            state <= SUB;
                        end
                    end
                end
                SUB: begin
                    if (sub_cnt != 3'd0) begin
                        s[2'(sub_cnt - 3'd1)] <= mem.sbox_q0;
                    end
                    if (sub_cnt == 3'd4) begin
                        s[0]    <= s[0] ^ rcon;
                        rcon    <= xtime(rcon, xt_poly);
                        sub_cnt <= '0;
                        state   <= WR;
                    end else begin
                        sub_cnt <= sub_cnt + 3'd1;
                    end
                end
                WR: begin
                    half <= ~half;
                    if (half) begin
                        col <= col + 1'b1;
                        if (col == CW'(NCOL - 1)) begin
                            state <= DONE;
                        end else if (col[1:0] == 2'b11) begin
                            state <= SUB;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
